dcache_wb: RTL

Set-associative, write-back, write-allocate data cache between the LSUs and the data memory controller. Requests from NUM_CONSUMERS LSUs are arbitrated round-robin and served one at a time. Hits complete in the cache. Misses evict a dirty victim byte-by-byte, then refill the block over a single memory channel. It replaces the hit-only data cache in front of the data controller.

---
 rtl/dcache_pkg.sv | 45 ++++
 rtl/dcache_wb_rr_arbiter.sv | 51 +++++
 rtl/dcache_wb.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types for the write-back data cache.
//   dcache_state_t   : controller FSM states
//   dcache_op_t      : latched request kind (read / write)
//   addr_field_width : offset, index and tag widths derived from the cache parameters
package dcache_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StWriteback,
      StRefill,
      StRespond
   } dcache_state_t;

   typedef enum logic {
      OpRead,
      OpWrite
   } dcache_op_t;

   typedef enum logic [1:0] {
      FieldOffset,
      FieldIndex,
      FieldTag
   } addr_field_t;

   // Address layout, MSB to LSB: tag | set index | byte offset.
   function automatic int unsigned addr_field_width(
      input addr_field_t field,
      input int unsigned addr_bits,
      input int unsigned num_blocks,
      input int unsigned num_ways,
      input int unsigned block_size
   );
      int unsigned off_w;
      int unsigned idx_w;
      off_w = $clog2(block_size);
      idx_w = $clog2(num_blocks / num_ways);
      case (field)
         FieldOffset: return off_w;
         FieldIndex:  return idx_w;
         default:     return addr_bits - idx_w - off_w;
      endcase
   endfunction

endpackage

// File: rtl/dcache_wb_rr_arbiter.sv
// rr_arbiter: round-robin arbiter. The search starts one past the last consumer granted
// with advance high.
//   clk, reset : clock, asynchronous active-high reset (pointer -> 0)
//   req        : request vector
//   advance    : accept the current grant and move the pointer past it
//   grant      : one-hot grant (all zero when no request)
//   grant_idx  : encoded index of the granted consumer
module rr_arbiter #(
   parameter int unsigned NUM_CONSUMERS = 8,
   localparam int unsigned IdxW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CONSUMERS-1:0] req,
   input  logic                     advance,
   output logic [NUM_CONSUMERS-1:0] grant,
   output logic [IdxW-1:0]          grant_idx
);

   logic [IdxW-1:0] ptr_q, ptr_d;
   int unsigned     cand;
   logic            found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
         cand = (32'(ptr_q) + i) % NUM_CONSUMERS;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IdxW'(cand);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         ptr_d = (grant_idx == IdxW'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: set-associative, write-back, write-allocate data cache shared by NUM_CONSUMERS
// LSUs. One request is served at a time; misses write back a dirty victim byte-by-byte and
// then refill the block over one memory channel.
//   clk, reset                : clock, asynchronous active-high reset
//   consumer_read_*           : per-LSU read request (valid/address) and response (ready/data)
//   consumer_write_*          : per-LSU write request (valid/address/data) and ready
//   mem_read_*                : refill beat request (valid/address) and return (ready/data)
//   mem_write_*               : writeback beat (valid/address/data) and ready
//   hit/miss/writeback_count  : performance counters
// Build option: define DCACHE_PERF_COUNTERS_EN to implement the counters; otherwise they
// read 0.
module dcache_wb
   import dcache_pkg::*;
#(
   parameter int unsigned ADDR_BITS        = 8,
   parameter int unsigned DATA_BITS        = 8,
   parameter int unsigned NUM_CONSUMERS    = 8,
   parameter int unsigned NUM_BLOCKS       = 8,
   parameter int unsigned NUM_WAYS         = 2,
   parameter int unsigned CACHE_BLOCK_SIZE = 4
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
   output logic                                    mem_read_valid,
   output logic [ADDR_BITS-1:0]                    mem_read_address,
   input  logic                                    mem_read_ready,
   input  logic [DATA_BITS-1:0]                    mem_read_data,
   output logic                                    mem_write_valid,
   output logic [ADDR_BITS-1:0]                    mem_write_address,
   output logic [DATA_BITS-1:0]                    mem_write_data,
   input  logic                                    mem_write_ready,
   output logic [31:0]                             hit_count,
   output logic [31:0]                             miss_count,
   output logic [31:0]                             writeback_count
);

   localparam int unsigned NumSets = NUM_BLOCKS / NUM_WAYS;
   localparam int unsigned OffW =
      addr_field_width(FieldOffset, ADDR_BITS, NUM_BLOCKS, NUM_WAYS, CACHE_BLOCK_SIZE);
   localparam int unsigned IdxW =
      addr_field_width(FieldIndex, ADDR_BITS, NUM_BLOCKS, NUM_WAYS, CACHE_BLOCK_SIZE);
   localparam int unsigned TagW =
      addr_field_width(FieldTag, ADDR_BITS, NUM_BLOCKS, NUM_WAYS, CACHE_BLOCK_SIZE);
   localparam int unsigned WayW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int unsigned CidW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   dcache_state_t                    state_q, state_d;
   dcache_op_t                       op_q, op_d;
   logic [CidW-1:0]                  cid_q, cid_d;
   logic [ADDR_BITS-1:0]             addr_q, addr_d;
   logic [DATA_BITS-1:0]             wdata_q, wdata_d;
   logic [DATA_BITS-1:0]             rdata_q, rdata_d;
   logic [WayW-1:0]                  way_q, way_d;
   logic [OffW-1:0]                  beat_q, beat_d;
   logic                             refilled_q, refilled_d;
   logic [NUM_CONSUMERS-1:0]         rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
   logic                             mem_rvalid_q, mem_rvalid_d, mem_wvalid_q, mem_wvalid_d;
   logic [ADDR_BITS-1:0]             mem_raddr_q, mem_raddr_d, mem_waddr_q, mem_waddr_d;
   logic [DATA_BITS-1:0]             mem_wdata_q, mem_wdata_d;
   logic [NumSets-1:0][NUM_WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
   logic [NumSets-1:0][WayW-1:0]     vptr_q, vptr_d;

   // Block storage is not reset; valid bits gate every use of it.
   logic [DATA_BITS-1:0] data_mem [NUM_WAYS][NumSets][CACHE_BLOCK_SIZE];
   logic [TagW-1:0]      tag_mem  [NUM_WAYS][NumSets];

   logic                 data_we, tag_we;
   logic [WayW-1:0]      data_way;
   logic [OffW-1:0]      data_off;
   logic [DATA_BITS-1:0] data_wdata;

   logic [OffW-1:0] req_off;
   logic [IdxW-1:0] req_set;
   logic [TagW-1:0] req_tag;
   logic            hit, inv_found;
   logic [WayW-1:0] hit_way, inv_way;
   logic            cnt_hit, cnt_miss, cnt_wb;

   logic [NUM_CONSUMERS-1:0] arb_req, arb_grant;
   logic [CidW-1:0]          arb_idx;
   logic                     arb_advance;

   assign req_off = addr_q[OffW-1:0];
   assign req_set = addr_q[OffW +: IdxW];
   assign req_tag = addr_q[ADDR_BITS-1 -: TagW];

   // A consumer still being acknowledged is not eligible again until its ready drops.
   assign arb_req = (consumer_read_valid | consumer_write_valid) & ~(rd_ready_q | wr_ready_q);

   rr_arbiter #(
      .NUM_CONSUMERS(NUM_CONSUMERS)
   ) u_arb (
      .clk      (clk),
      .reset    (reset),
      .req      (arb_req),
      .advance  (arb_advance),
      .grant    (arb_grant),
      .grant_idx(arb_idx)
   );

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[req_set][w] && (tag_mem[w][req_set] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WayW'(w);
         end
         if (!valid_q[req_set][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WayW'(w);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      cid_d        = cid_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      way_d        = way_q;
      beat_d       = beat_q;
      refilled_d   = refilled_q;
      rd_ready_d   = rd_ready_q;
      wr_ready_d   = wr_ready_q;
      mem_rvalid_d = mem_rvalid_q;
      mem_raddr_d  = mem_raddr_q;
      mem_wvalid_d = mem_wvalid_q;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      vptr_d       = vptr_q;
      data_we      = 1'b0;
      data_way     = way_q;
      data_off     = beat_q;
      data_wdata   = mem_read_data;
      tag_we       = 1'b0;
      arb_advance  = 1'b0;
      cnt_hit      = 1'b0;
      cnt_miss     = 1'b0;
      cnt_wb       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|arb_grant) begin
               arb_advance = 1'b1;
               cid_d       = arb_idx;
               wdata_d     = consumer_write_data[arb_idx];
               refilled_d  = 1'b0;
               state_d     = StLookup;
               // A consumer raising both valids gets its read served first.
               if (consumer_read_valid[arb_idx]) begin
                  op_d   = OpRead;
                  addr_d = consumer_read_address[arb_idx];
               end else begin
                  op_d   = OpWrite;
                  addr_d = consumer_write_address[arb_idx];
               end
            end
         end

         StLookup: begin
            if (hit) begin
               if (op_q == OpRead) begin
                  rdata_d = data_mem[hit_way][req_set][req_off];
               end else begin
                  data_we                   = 1'b1;
                  data_way                  = hit_way;
                  data_off                  = req_off;
                  data_wdata                = wdata_q;
                  dirty_d[req_set][hit_way] = 1'b1;
               end
               cnt_hit = !refilled_q;
               state_d = StRespond;
            end else begin
               cnt_miss = 1'b1;
               beat_d   = '0;
               way_d    = inv_found ? inv_way : vptr_q[req_set];
               // With no invalid way the victim is always valid; only dirty matters.
               if (!inv_found && dirty_q[req_set][vptr_q[req_set]]) state_d = StWriteback;
               else                                                  state_d = StRefill;
            end
         end

         StWriteback: begin
            if (!mem_wvalid_q) begin
               mem_wvalid_d = 1'b1;
               mem_waddr_d  = {tag_mem[way_q][req_set], req_set, beat_q};
               mem_wdata_d  = data_mem[way_q][req_set][beat_q];
            end else if (mem_write_ready) begin
               mem_wvalid_d = 1'b0;
               beat_d       = beat_q + 1'b1;
               if (beat_q == OffW'(CACHE_BLOCK_SIZE - 1)) begin
                  cnt_wb  = 1'b1;
                  state_d = StRefill;
               end
            end
         end

         StRefill: begin
            if (!mem_rvalid_q) begin
               mem_rvalid_d = 1'b1;
               mem_raddr_d  = {req_tag, req_set, beat_q};
            end else if (mem_read_ready) begin
               mem_rvalid_d = 1'b0;
               data_we      = 1'b1;
               beat_d       = beat_q + 1'b1;
               if (beat_q == OffW'(CACHE_BLOCK_SIZE - 1)) begin
                  tag_we                  = 1'b1;
                  valid_d[req_set][way_q] = 1'b1;
                  dirty_d[req_set][way_q] = 1'b0;
                  vptr_d[req_set] = (vptr_q[req_set] == WayW'(NUM_WAYS - 1)) ?
                                    '0 : vptr_q[req_set] + 1'b1;
                  refilled_d      = 1'b1;
                  state_d         = StLookup;
               end
            end
         end

         StRespond: begin
            if (op_q == OpRead) begin
               if (!rd_ready_q[cid_q]) begin
                  rd_ready_d[cid_q] = 1'b1;
               end else if (!consumer_read_valid[cid_q]) begin
                  rd_ready_d = '0;
                  state_d    = StIdle;
               end
            end else begin
               if (!wr_ready_q[cid_q]) begin
                  wr_ready_d[cid_q] = 1'b1;
               end else if (!consumer_write_valid[cid_q]) begin
                  wr_ready_d = '0;
                  state_d    = StIdle;
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         op_q         <= OpRead;
         cid_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         way_q        <= '0;
         beat_q       <= '0;
         refilled_q   <= 1'b0;
         rd_ready_q   <= '0;
         wr_ready_q   <= '0;
         mem_rvalid_q <= 1'b0;
         mem_raddr_q  <= '0;
         mem_wvalid_q <= 1'b0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         vptr_q       <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         cid_q        <= cid_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         way_q        <= way_d;
         beat_q       <= beat_d;
         refilled_q   <= refilled_d;
         rd_ready_q   <= rd_ready_d;
         wr_ready_q   <= wr_ready_d;
         mem_rvalid_q <= mem_rvalid_d;
         mem_raddr_q  <= mem_raddr_d;
         mem_wvalid_q <= mem_wvalid_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         vptr_q       <= vptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) data_mem[data_way][req_set][data_off] <= data_wdata;
      if (tag_we)  tag_mem[way_q][req_set] <= req_tag;
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
         consumer_read_data[i] = rd_ready_q[i] ? rdata_q : '0;
      end
   end

   assign consumer_read_ready  = rd_ready_q;
   assign consumer_write_ready = wr_ready_q;
   assign mem_read_valid       = mem_rvalid_q;
   assign mem_read_address     = mem_raddr_q;
   assign mem_write_valid      = mem_wvalid_q;
   assign mem_write_address    = mem_waddr_q;
   assign mem_write_data       = mem_wdata_q;

`ifdef DCACHE_PERF_COUNTERS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         if (cnt_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (cnt_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
         if (cnt_wb)   wb_cnt_q   <= wb_cnt_q + 32'd1;
      end
   end

   assign hit_count       = hit_cnt_q;
   assign miss_count      = miss_cnt_q;
   assign writeback_count = wb_cnt_q;
`else
   logic unused_cnt;
   assign unused_cnt      = ^{cnt_hit, cnt_miss, cnt_wb};
   assign hit_count       = '0;
   assign miss_count      = '0;
   assign writeback_count = '0;
`endif

endmodule
